// File: rtl/ballot_arbiter_pkg.sv
// ballot_arbiter_pkg: shared vote-path defaults, FSM encoding and tally width.
package ballot_arbiter_pkg;
  localparam int NB_DEF = 4;
  localparam int CW_DEF = 4;
  localparam int TW = 12;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, SEND = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/ballot_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first eligible booth at or above rr_ptr with wrap.
module rr_pick #(
  parameter int NB = 4,
  localparam int SW = $clog2(NB)
) (
  input  logic [NB-1:0] eligible,
  input  logic [SW-1:0] rr_ptr,
  output logic [SW-1:0] winner,
  output logic          found
);
  logic [SW:0] idx;
  // Scan highest offset first so the nearest eligible booth overwrites the rest.
  always_comb begin
    winner = '0;
    found = 1'b0;
    idx = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (SW + 1)'(i);
      idx = idx >= (SW + 1)'(NB) ? idx - (SW + 1)'(NB) : idx;
      if (eligible[idx[SW-1:0]]) begin
        winner = idx[SW-1:0];
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ballot_arbiter.sv
// ballot_arbiter: arbitrates armed booths onto a single vote path with round-robin fairness.
module ballot_arbiter
  import ballot_arbiter_pkg::*;
#(
  parameter int NB = NB_DEF,
  parameter int CW = CW_DEF,
  localparam int SW = $clog2(NB)
) (
  input  logic             clk,
  input  logic             Power,
  input  logic             Close,
  input  logic             issue,
  input  logic [SW-1:0]    issue_sel,
  input  logic [NB-1:0]    req,
  input  logic [NB*CW-1:0] cand,
  output logic [NB-1:0]    armed,
  output logic [NB-1:0]    ack,
  output logic [NB-1:0]    nack,
  output logic             vote_valid,
  output logic [CW-1:0]    vote_cand,
  input  logic             vote_ready,
  output logic             busy,
  output logic [TW-1:0]    vote_total
);
  state_t state_q, state_d;
  logic [SW-1:0] rr_q, rr_d, win_q, win_d, winner;
  logic [CW-1:0] code_q, code_d;
  logic [NB-1:0] armed_q, armed_d, eligible;
  logic [TW-1:0] total_q, total_d;
  logic found, issue_ok;
  assign eligible = Close ? '0 : req & armed_q;
  rr_pick #(.NB(NB)) u_pick (.eligible(eligible), .rr_ptr(rr_q), .winner(winner), .found(found));
  assign busy = state_q != IDLE;
  assign vote_valid = state_q == SEND;
  assign vote_cand = vote_valid ? code_q : '0;
  assign ack = state_q == DONE ? NB'(1) << win_q : '0;
  assign nack = (state_q == GRANT && code_q == '0) ? NB'(1) << win_q : '0;
  assign armed = armed_q;
  assign vote_total = total_q;
  // The current winner cannot be re-armed until it has been disarmed on the way out of DONE.
  assign issue_ok = issue && !Close && !armed_q[issue_sel] && ({1'b0, issue_sel} < (SW + 1)'(NB))
                    && !(busy && issue_sel == win_q);
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    win_d = win_q;
    code_d = code_q;
    armed_d = armed_q;
    total_d = total_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        win_d = winner;
        code_d = cand[winner*CW +: CW];
      end
      GRANT: state_d = code_q == '0 ? IDLE : SEND;
      SEND: state_d = vote_ready ? DONE : SEND;
      DONE: begin
        state_d = IDLE;
        armed_d[win_q] = 1'b0;
        total_d = total_q + TW'(total_q != '1);
        rr_d = win_q == SW'(NB - 1) ? '0 : win_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (issue_ok) armed_d[issue_sel] = 1'b1;
  end
  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      state_q <= IDLE;
      rr_q <= '0;
      win_q <= '0;
      code_q <= '0;
      armed_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      win_q <= win_d;
      code_q <= code_d;
      armed_q <= armed_d;
      total_q <= total_d;
    end
  end
endmodule

// File: tb/tb_ballot_arbiter.sv
// tb_ballot_arbiter: directed scenarios plus randomized rounds against a transaction-level vote model.
module tb_ballot_arbiter;
  localparam int NB = 4;
  localparam int CW = 4;
  logic clk, Power, Close, issue, vote_ready, vote_valid, busy;
  logic [1:0] issue_sel;
  logic [NB-1:0] req, armed, ack, nack;
  logic [NB*CW-1:0] cand;
  logic [CW-1:0] vote_cand;
  logic [11:0] vote_total;
  int checks = 0;
  int failures = 0;

  ballot_arbiter #(.NB(NB), .CW(CW)) dut (
    .clk(clk), .Power(Power), .Close(Close), .issue(issue), .issue_sel(issue_sel),
    .req(req), .cand(cand), .armed(armed), .ack(ack), .nack(nack),
    .vote_valid(vote_valid), .vote_cand(vote_cand), .vote_ready(vote_ready),
    .busy(busy), .vote_total(vote_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_issue(input int b);
    issue = 1'b1;
    issue_sel = 2'(b);
    @(negedge clk);
    issue = 1'b0;
  endtask

  function automatic int pick(input logic [NB-1:0] p, input int rr);
    for (int k = 0; k < NB; k++) if (p[(rr + k) % NB]) return (rr + k) % NB;
    return 0;
  endfunction

  function automatic int idx_of(input logic [NB-1:0] v);
    for (int k = 0; k < NB; k++) if (v[k]) return k;
    return 15;
  endfunction

  initial begin
    logic [11:0] ordv;
    int nord, nk, vv, ak, stable, cyc, w, evs, got;
    logic [NB-1:0] armed_m, pend, ackv;
    int rr_m, total_m;
    logic [CW-1:0] c [NB];
    Power = 1'b1; Close = 1'b0; issue = 1'b0; issue_sel = '0; req = '0; cand = '0; vote_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_armed", armed, 0); chk("rst_ack", ack, 0); chk("rst_nack", nack, 0);
    chk("rst_valid", vote_valid, 0); chk("rst_cand", vote_cand, 0);
    chk("rst_busy", busy, 0); chk("rst_total", vote_total, 0);
    Power = 1'b0;
    @(negedge clk);
    // single vote from booth 1, latency 3
    do_issue(1);
    chk("arm1", armed, 4'b0010);
    cand[7:4] = 4'd5; req[1] = 1'b1; vote_ready = 1'b1;
    @(negedge clk); chk("v1_grant_busy", busy, 1); chk("v1_grant_novalid", vote_valid, 0);
    @(negedge clk); chk("v1_send_valid", vote_valid, 1); chk("v1_send_cand", vote_cand, 5);
    @(negedge clk); chk("v1_ack", ack, 4'b0010);
    req[1] = 1'b0;
    @(negedge clk); chk("v1_disarm", armed, 0); chk("v1_total", vote_total, 1);
    // round-robin order from rr_ptr=2
    do_issue(0); do_issue(2); do_issue(3);
    chk("rr_armed", armed, 4'b1101);
    cand = 16'h3201; req = 4'b1101;
    ordv = '0; nord = 0;
    for (int i = 0; i < 60 && req != 0; i++) begin
      @(negedge clk);
      if (ack != 0) begin
        ordv = {ordv[7:0], 4'(idx_of(ack))};
        nord++;
        req &= ~ack;
      end
    end
    @(negedge clk);
    chk("rr_count", nord, 3); chk("rr_order", ordv, 12'h230); chk("rr_total", vote_total, 4);
    // null ballot is rejected, booth stays armed
    do_issue(0);
    cand[3:0] = 4'd0; req[0] = 1'b1; nk = 0; vv = 0; ak = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (nack[0]) begin nk++; req[0] = 1'b0; end
      if (vote_valid) vv = 1;
      if (ack != 0) ak = 1;
    end
    chk("null_nack", nk, 1); chk("null_novalid", vv, 0); chk("null_noack", ak, 0);
    chk("null_armed", armed, 4'b0001); chk("null_total", vote_total, 4);
    // stalled handshake with Close raised mid-wait
    do_issue(2);
    cand[11:8] = 4'd9; cand[3:0] = 4'd7; req[2] = 1'b1; vote_ready = 1'b0;
    repeat (2) @(negedge clk);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (vote_valid && vote_cand == 4'd9) stable++;
      if (i == 4) begin Close = 1'b1; req[0] = 1'b1; end
      @(negedge clk);
    end
    chk("stall_stable", stable, 10);
    vote_ready = 1'b1; ackv = '0;
    for (int i = 0; i < 10 && ackv == 0; i++) begin
      @(negedge clk);
      ackv = ack;
    end
    req[2] = 1'b0;
    chk("close_ack", ackv, 4'b0100);
    do_issue(1);
    chk("close_issue", armed, 4'b0001);
    evs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || ack != 0 || nack != 0) evs++;
    end
    chk("close_hold", evs, 0); chk("close_total", vote_total, 5);
    req[0] = 1'b0; Close = 1'b0;
    // issue to busy winner / armed booth, then reset mid-SEND
    do_issue(3);
    cand[15:12] = 4'd4; req[3] = 1'b1; vote_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("b3_send", vote_valid, 1);
    do_issue(3); do_issue(0);
    chk("busy_issue_armed", armed, 4'b1001); chk("busy_still_send", vote_valid, 1);
    #2 Power = 1'b1;
    #1;
    chk("pwr_armed", armed, 0); chk("pwr_valid", vote_valid, 0); chk("pwr_cand", vote_cand, 0);
    chk("pwr_busy", busy, 0); chk("pwr_total", vote_total, 0); chk("pwr_acknack", {ack, nack}, 0);
    @(negedge clk);
    Power = 1'b0; req = '0; vote_ready = 1'b1; ak = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (ack != 0) ak = 1; end
    chk("pwr_noack", ak, 0); chk("pwr_disarm", armed, 0);
    // randomized rounds against the model
    armed_m = '0; rr_m = 0; total_m = 0;
    for (int r = 0; r < 30; r++) begin
      for (int b = 0; b < NB; b++) if ($urandom_range(1, 0) == 1) begin do_issue(b); armed_m[b] = 1'b1; end
      chk("rnd_armed_pre", armed, armed_m);
      for (int b = 0; b < NB; b++) begin
        c[b] = ($urandom_range(3, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
        cand[b*CW +: CW] = c[b];
      end
      req = 4'($urandom_range(15, 0));
      pend = req & armed_m;
      cyc = 0;
      while ((pend != 0 || busy) && cyc < 400) begin
        vote_ready = 1'($urandom_range(1, 0));
        @(negedge clk);
        cyc++;
        w = pick(pend, rr_m);
        if (vote_valid) chk("rnd_cand", vote_cand, c[w]);
        else chk("rnd_cand_zero", vote_cand, 0);
        if ((ack | nack) != 0) begin
          chk("rnd_onehot", ack | nack, 1 << w);
          chk("rnd_kind", ack != 0, c[w] != 0);
          if (c[w] != 0) begin
            armed_m[w] = 1'b0;
            total_m = total_m == 4095 ? 4095 : total_m + 1;
            rr_m = (w + 1) % NB;
          end
          pend[w] = 1'b0;
          req[w] = 1'b0;
        end
      end
      chk("rnd_drain", pend, 0);
      evs = 0;
      for (int i = 0; i < 4; i++) begin @(negedge clk); if (ack != 0 || nack != 0) evs++; end
      chk("rnd_quiet", evs, 0);
      req = '0;
      chk("rnd_armed", armed, armed_m); chk("rnd_total", vote_total, total_m);
    end
    // drive the tally past saturation
    vote_ready = 1'b1; cand[3:0] = 4'd1;
    while (total_m < 4097) begin
      do_issue(0);
      req[0] = 1'b1; got = 0;
      for (int i = 0; i < 12 && got == 0; i++) begin @(negedge clk); if (ack[0]) got = 1; end
      req[0] = 1'b0;
      @(negedge clk);
      chk("sat_ack", got, 1);
      if (got == 0) break;
      total_m++;
    end
    chk("sat_total", vote_total, 12'hfff);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
